pixel_fetcher: RTL and testbench
================================

PIXEL_FETCHER -- requirements
Module: pixel_fetcher

Interface
REQ-001 Parameter BASE_ADDR, default 0: word address of the first framebuffer pixel.
REQ-002 Parameter FRAME_PIXELS, default 307200: pixels per frame (640x480).
REQ-003 Parameter ADDR_W, default 19: memAddr width.
REQ-004 Parameter FIFO_DEPTH, default 16: prefetch FIFO entries; power of two, minimum 4.
REQ-005 vgaClk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 frameStart  in  1  one-cycle pulse per frame, issued in vertical blanking.
REQ-008 videoOnIn  in  1  active-area flag from the VGA timing generator.
REQ-009 memReq  out  1  read request to framebuffer memory.
REQ-010 memAddr  out  ADDR_W  read word address.
REQ-011 memGnt  in  1  request accepted this cycle.
REQ-012 memValid  in  1  read data valid; responses return in request order.
REQ-013 memData  in  8  returned palette index.
REQ-014 videoOn  out  1  videoOnIn delayed by one cycle, aligned to color_index.
REQ-015 color_index  out  8  palette index for the palette-lookup stage.
REQ-016 underflow  out  1  sticky; FIFO was empty while videoOnIn=1.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH and DONE; reset enters IDLE.
REQ-018 IDLE: memReq=0; frameStart moves the FSM to FETCH.
REQ-019 FETCH: memReq=1 only while fifoCount+outstanding < FIFO_DEPTH (credit rule).
REQ-020 memAddr SHALL hold stable while memReq=1 and memGnt=0.
REQ-021 A grant SHALL increment memAddr by 1 and outstanding by 1.
REQ-022 A grant at address BASE_ADDR+FRAME_PIXELS-1 SHALL move the FSM to DONE; DONE keeps memReq=0.
REQ-023 A memValid response SHALL push memData into the FIFO and decrement outstanding; a same-cycle grant and response leave outstanding unchanged.
REQ-024 The credit rule guarantees no push to a full FIFO; same-cycle push and pop SHALL both occur.
REQ-025 In any state, frameStart SHALL empty the FIFO, load memAddr=BASE_ADDR, clear underflow, load discardCnt=outstanding (counting any same-cycle grant) and force outstanding to 0.
REQ-026 A frameStart arriving in FETCH, DONE or IDLE SHALL enter FETCH on the next cycle.
REQ-027 While discardCnt>0, each memValid SHALL be dropped and discardCnt decremented; this includes a memValid in the same cycle as frameStart.
REQ-028 While discardCnt>0, those stale responses SHALL remain counted against credit.
REQ-029 Pop: when videoOnIn=1 and the FIFO is non-empty, the head is popped and registered into color_index; latency one cycle.
REQ-030 When videoOnIn=1 and the FIFO is empty, color_index SHALL become 0x00 next cycle and underflow SHALL be set.
REQ-031 When videoOnIn=0, color_index SHALL become 0x00 next cycle and nothing is popped.
REQ-032 videoOn SHALL equal videoOnIn registered once.

Reset
REQ-033 On rst=1 the block SHALL asynchronously clear memReq, videoOn, color_index, underflow, memAddr (to BASE_ADDR), the FIFO pointers, outstanding and discardCnt, and enter IDLE.
REQ-034 Requests in flight when rst asserts are not tracked; memory is reset together with this block.

Configuration
REQ-035 With macro PIXEL_FETCHER_UFLOW_CNT_EN defined, the block SHALL add output underflowCount[15:0].
REQ-036 underflowCount increments once per underflow cycle, saturates at 0xFFFF, clears on rst and on frameStart.
REQ-037 Without PIXEL_FETCHER_UFLOW_CNT_EN, underflowCount and its logic SHALL be absent; all other behaviour is identical.

Verification (FRAME_PIXELS=8, FIFO_DEPTH=4, BASE_ADDR=0x100)
REQ-038 Setup: rst, then frameStart, memGnt=1, 1-cycle-latency memory returning data=addr[7:0]. Check: addresses 0x100..0x103 are issued, then memReq=0 (credit exhausted).
REQ-039 From REQ-038, 8 videoOnIn cycles. Check: color_index=0x00..0x07 each one cycle after videoOnIn, videoOn aligned, FSM in DONE, underflow=0.
REQ-040 Stall: memGnt=0 for 5 cycles after frameStart. Check: memAddr=0x100 held with memReq=1; videoOnIn=1 meanwhile gives color_index=0 and underflow=1 (count=5 with macro).
REQ-041 Flush: frameStart with 3 outstanding and 1 FIFO entry. Check: the 3 late memValid are dropped, the next popped index is 0x00 from address 0x100, underflow cleared.
REQ-042 Reset mid-FETCH: rst pulse at memAddr=0x105. Check: all outputs 0, memAddr=0x100, no memReq until the next frameStart.

Source files
------------

// File: rtl/pixel_fetcher.sv
// -----------------------------------------------------------------------------
// pixel_fetcher
//   Prefetches one frame of palette indices from framebuffer memory into a
//   small FIFO. Each cycle with videoOnIn=1 it pops one index into color_index.
//   Requests are credit-limited, so every request issued already has a FIFO
//   slot reserved for its response.
//
// Ports
//   vgaClk          sole clock (rising edge)
//   rst             asynchronous, active-high reset
//   frameStart      one-cycle pulse per frame; restarts fetching at BASE_ADDR
//   videoOnIn       active-area flag from the timing generator
//   memReq/memAddr  read request and word address to framebuffer memory
//   memGnt          request accepted this cycle
//   memValid/memData in-order read response (palette index)
//   videoOn         videoOnIn delayed one cycle, aligned to color_index
//   color_index     palette index for the palette-lookup stage
//   underflow       sticky; FIFO was empty while videoOnIn=1
//   underflowCount  (only with PIXEL_FETCHER_UFLOW_CNT_EN) saturating count
//                   of underflow cycles
//
// Build option: define PIXEL_FETCHER_UFLOW_CNT_EN to add underflowCount.
// -----------------------------------------------------------------------------
module pixel_fetcher #(
   parameter int unsigned BASE_ADDR    = 0,
   parameter int unsigned FRAME_PIXELS = 307200,
   parameter int unsigned ADDR_W       = 19,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic              vgaClk,
   input  logic              rst,
   input  logic              frameStart,
   input  logic              videoOnIn,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic              memGnt,
   input  logic              memValid,
   input  logic [7:0]        memData,
   output logic              videoOn,
   output logic [7:0]        color_index,
   output logic              underflow
`ifdef PIXEL_FETCHER_UFLOW_CNT_EN
   ,
   output logic [15:0]       underflowCount
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + FRAME_PIXELS - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [7:0]        r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_outstanding;
   logic [CNT_W-1:0]  r_discard;
   logic [ADDR_W-1:0] r_addr;
   logic              r_video_on;
   logic [7:0]        r_color;
   logic              r_underflow;

   logic              w_req;
   logic              w_gnt;
   logic              w_empty;
   logic              w_drop;
   logic              w_push;
   logic              w_pop;
   logic [SUM_W-1:0]  w_credit_sum;
   logic [SUM_W-1:0]  w_discard_load;

   // Stale responses still awaiting discard hold FIFO credit, so they are
   // part of the sum alongside live entries and live outstanding requests.
   assign w_credit_sum = SUM_W'(r_count) + SUM_W'(r_outstanding) + SUM_W'(r_discard);
   assign w_empty      = (r_count == '0);
   assign w_gnt        = w_req & memGnt;
   assign w_drop       = memValid & (r_discard != '0);
   assign w_push       = memValid & ~w_drop & ~frameStart;
   assign w_pop        = videoOnIn & ~w_empty;

   // On frameStart every in-flight response becomes stale, including one
   // granted this cycle; a response arriving this same cycle is retired
   // against that total rather than pushed.
   assign w_discard_load = SUM_W'(r_discard) + SUM_W'(r_outstanding)
                         + SUM_W'(w_gnt) - SUM_W'(memValid);

   always_ff @(posedge vgaClk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      unique case (r_state)
         S_IDLE:  ;
         S_FETCH: begin
            w_req = (w_credit_sum < SUM_W'(FIFO_DEPTH));
            if (w_req && memGnt && (r_addr == LAST_ADDR)) w_state_next = S_DONE;
         end
         S_DONE:  ;
         default: w_state_next = S_IDLE;
      endcase
      if (frameStart) w_state_next = S_FETCH;
   end

   always_ff @(posedge vgaClk or posedge rst) begin
      if (rst) begin
         r_addr        <= FIRST_ADDR;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_video_on    <= 1'b0;
         r_color       <= '0;
         r_underflow   <= 1'b0;
      end else begin
         r_video_on <= videoOnIn;
         r_color    <= w_pop ? r_fifo[r_rd_ptr] : '0;
         if (frameStart) begin
            r_addr        <= FIRST_ADDR;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= CNT_W'(w_discard_load);
            r_underflow   <= 1'b0;
         end else begin
            if (w_gnt)  r_addr   <= r_addr + ADDR_W'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
            unique case ({w_gnt, w_push})
               2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
               2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
               default: r_outstanding <= r_outstanding;
            endcase
            if (w_drop) r_discard <= r_discard - CNT_W'(1);
            if (videoOnIn && w_empty) r_underflow <= 1'b1;
         end
      end
   end

   // FIFO storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge vgaClk) begin
      if (w_push) r_fifo[r_wr_ptr] <= memData;
   end

`ifdef PIXEL_FETCHER_UFLOW_CNT_EN
   logic [15:0] r_uflow_cnt;

   always_ff @(posedge vgaClk or posedge rst) begin
      if (rst)                                              r_uflow_cnt <= '0;
      else if (frameStart)                                  r_uflow_cnt <= '0;
      else if (videoOnIn && w_empty && (r_uflow_cnt != '1)) r_uflow_cnt <= r_uflow_cnt + 16'd1;
   end

   assign underflowCount = r_uflow_cnt;
`endif

   assign memReq      = w_req;
   assign memAddr     = r_addr;
   assign videoOn     = r_video_on;
   assign color_index = r_color;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_pixel_fetcher.sv
// -----------------------------------------------------------------------------
// tb_pixel_fetcher
//   Randomized scoreboard bench for pixel_fetcher (BASE_ADDR=0x100,
//   FRAME_PIXELS=8, FIFO_DEPTH=4). A frame-level reference model tracks which
//   requests belong to the current frame, how many of their responses are
//   buffered, and which pixel is due next; expected pixels are queued at
//   stimulus time and consumed by an independent monitor when videoOn=1.
// -----------------------------------------------------------------------------
module tb_pixel_fetcher;

   localparam int unsigned BASE  = 32'h100;
   localparam int unsigned FRAME = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 19;

   logic          vgaClk = 1'b0;
   logic          rst = 1'b0;
   logic          frameStart = 1'b0;
   logic          videoOnIn = 1'b0;
   logic          memReq;
   logic [AW-1:0] memAddr;
   logic          memGnt = 1'b0;
   logic          memValid = 1'b0;
   logic [7:0]    memData = 8'h00;
   logic          videoOn;
   logic [7:0]    color_index;
   logic          underflow;
`ifdef PIXEL_FETCHER_UFLOW_CNT_EN
   logic [15:0]   underflowCount;
`endif

   always #5 vgaClk = ~vgaClk;

   pixel_fetcher #(
      .BASE_ADDR(BASE),
      .FRAME_PIXELS(FRAME),
      .ADDR_W(AW),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .vgaClk(vgaClk),
      .rst(rst),
      .frameStart(frameStart),
      .videoOnIn(videoOnIn),
      .memReq(memReq),
      .memAddr(memAddr),
      .memGnt(memGnt),
      .memValid(memValid),
      .memData(memData),
      .videoOn(videoOn),
      .color_index(color_index),
      .underflow(underflow)
`ifdef PIXEL_FETCHER_UFLOW_CNT_EN
      ,
      .underflowCount(underflowCount)
`endif
   );

   typedef struct {
      int            tag;
      logic [AW-1:0] addr;
   } req_t;

   req_t       pending[$];   // requests granted, response not yet returned
   logic [7:0] exp_q[$];     // expected color_index for each videoOn cycle

   int total = 0;
   int bad   = 0;

   // reference model state
   int frame_id = 0;
   int avail    = 0;   // current-frame pixels buffered, not yet shown
   int popidx   = 0;   // next pixel of the frame to be shown
   int grants   = 0;   // requests granted in the current frame
   bit fetching = 0;
   bit m_uflow  = 0;
   int ucnt     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_req();
      return fetching && (grants < int'(FRAME)) &&
             ((avail + int'(pending.size())) < int'(DEPTH));
   endfunction

   // One clock of stimulus. mode: 0 = memory holds responses,
   // 1 = respond whenever possible (1-cycle latency), 2 = random latency.
   task automatic cycle(input bit fs, input bit vin, input bit gnt, input int mode);
      bit   req_s;
      bit   valid;
      req_t h;
      @(negedge vgaClk);
      req_s = memReq;
      check("memReq", 32'(memReq), 32'(exp_req()));
      if (req_s) check("memAddr", 32'(memAddr), BASE + 32'(grants));
      check("underflow", 32'(underflow), 32'(m_uflow));
`ifdef PIXEL_FETCHER_UFLOW_CNT_EN
      check("underflowCount", 32'(underflowCount), 32'(ucnt));
`endif
      valid = 1'b0;
      if (pending.size() > 0) begin
         case (mode)
            1:       valid = 1'b1;
            2:       valid = ($urandom_range(0, 2) != 0);
            default: valid = 1'b0;
         endcase
      end
      frameStart = fs;
      videoOnIn  = vin && !fs;
      memGnt     = gnt;
      memValid   = valid;
      memData    = valid ? pending[0].addr[7:0] : 8'($urandom);

      // model the coming edge
      if (videoOnIn) begin
         if (avail > 0) begin
            exp_q.push_back(8'(BASE + 32'(popidx)));
            popidx++;
            avail--;
         end else begin
            exp_q.push_back(8'h00);
            m_uflow = 1'b1;
            if (ucnt < 65535) ucnt++;
         end
      end
      if (req_s && gnt) begin
         pending.push_back('{frame_id, AW'(BASE + 32'(grants))});
         grants++;
      end
      if (valid) begin
         h = pending.pop_front();
         if (h.tag == frame_id && !fs) avail++;
      end
      if (fs) begin
         frame_id++;
         avail    = 0;
         popidx   = 0;
         grants   = 0;
         fetching = 1'b1;
         m_uflow  = 1'b0;
         ucnt     = 0;
      end
   endtask

   task automatic do_reset();
      frameStart = 1'b0;
      videoOnIn  = 1'b0;
      memGnt     = 1'b0;
      memValid   = 1'b0;
      memData    = 8'h00;
      #1 rst = 1'b1;
      #1;
      check("rst_memReq", 32'(memReq), 32'd0);
      check("rst_memAddr", 32'(memAddr), BASE);
      check("rst_videoOn", 32'(videoOn), 32'd0);
      check("rst_color", 32'(color_index), 32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
`ifdef PIXEL_FETCHER_UFLOW_CNT_EN
      check("rst_underflowCount", 32'(underflowCount), 32'd0);
`endif
      pending.delete();
      exp_q.delete();
      frame_id++;
      avail    = 0;
      popidx   = 0;
      grants   = 0;
      fetching = 1'b0;
      m_uflow  = 1'b0;
      ucnt     = 0;
      @(negedge vgaClk);
      #1 rst = 1'b0;
   endtask

   // monitor: compares each presented pixel against the scoreboard
   always @(negedge vgaClk) begin
      if (!rst) begin
         if (videoOn) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL color_index: videoOn with nothing expected, got %0h (t=%0t)",
                        color_index, $time);
            end else begin
               check("color_index", 32'(color_index), 32'(exp_q.pop_front()));
            end
         end else begin
            check("color_blank", 32'(color_index), 32'd0);
         end
      end
   end

   initial begin
      bit found;
      int n;

      do_reset();

      // nominal frame: prefetch fills the FIFO, then 8 pixels displayed
      cycle(1'b1, 1'b0, 1'b1, 1);
      repeat (10) cycle(1'b0, 1'b0, 1'b1, 1);
      repeat (8)  cycle(1'b0, 1'b1, 1'b1, 1);
      repeat (4)  cycle(1'b0, 1'b0, 1'b1, 1);

      // grant stall with active video: underflow while memAddr holds
      cycle(1'b1, 1'b0, 1'b0, 1);
      repeat (5)  cycle(1'b0, 1'b1, 1'b0, 1);
      repeat (12) cycle(1'b0, 1'b0, 1'b1, 1);
      repeat (8)  cycle(1'b0, 1'b1, 1'b1, 1);

      // flush: 3 outstanding + 1 buffered when frameStart arrives
      cycle(1'b1, 1'b0, 1'b0, 1);
      repeat (6)  cycle(1'b0, 1'b0, 1'b1, 0);
      cycle(1'b0, 1'b0, 1'b0, 1);
      cycle(1'b1, 1'b0, 1'b0, 0);
      repeat (10) cycle(1'b0, 1'b0, 1'b1, 1);
      repeat (8)  cycle(1'b0, 1'b1, 1'b1, 1);

      // reset in the middle of fetching
      cycle(1'b1, 1'b0, 1'b0, 1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(1'b0, (i >= 6), 1'b1, 1);
         if (memAddr == AW'(BASE + 5)) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL reach_addr_105: got %0h expected %0h", memAddr, AW'(BASE + 5));
      end
      do_reset();
      repeat (5) cycle(1'b0, 1'b0, 1'b1, 1);

      // random frames, frequently cut short by the next frameStart
      for (int f = 0; f < 30; f++) begin
         cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2);
         n = int'($urandom_range(10, 40));
         repeat (n) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
      end

      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1);
      @(negedge vgaClk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
